iommu_entry_alloc: RTL
======================

IOMMU_ENTRY_ALLOC -- requirements
Module: iommu_entry_alloc

Interface
REQ-001 SHALL have parameter NumEntries, default 16, number of tracked cache entries (2..64, power of two not required).
REQ-002 SHALL have derived parameter IdxWidth, default cf_math_pkg::idx_width(NumEntries), entry index width; never overridden.
REQ-003 SHALL have derived parameter CntWidth, default $clog2(NumEntries+1), occupancy count width; never overridden.
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port alloc_req_i  input  1  request one free entry this cycle.
REQ-007 SHALL have port alloc_gnt_o  output  1  request granted this cycle.
REQ-008 SHALL have port alloc_idx_o  output  IdxWidth  granted entry index; meaningful only with alloc_gnt_o.
REQ-009 SHALL have port alloc_evict_o  output  1  granted entry was valid, i.e. a victim.
REQ-010 SHALL have port free_valid_i  input  1  release one entry.
REQ-011 SHALL have port free_idx_i  input  IdxWidth  index to release.
REQ-012 SHALL have port flush_i  input  1  invalidate all entries.
REQ-013 SHALL have port valid_o  output  NumEntries  registered valid bitmap.
REQ-014 SHALL have port count_o  output  CntWidth  registered number of set valid bits.
REQ-015 SHALL have ports full_o and empty_o, both output, 1 bit each: all entries valid / none valid, from registered state.

Function
REQ-016 Free candidate SHALL be the lowest-index clear bit of valid_o, found with a trailing-zero count of ~valid_o.
REQ-017 alloc_gnt_o SHALL be combinational: alloc_req_i and not flush_i and (not full_o or victim mode active).
REQ-018 When not full, alloc_idx_o SHALL be the free candidate and alloc_evict_o SHALL be 0.
REQ-019 A grant SHALL set valid[alloc_idx_o] on the next rising edge: one-cycle latency to valid_o and count_o.
REQ-020 free_valid_i SHALL clear valid[free_idx_i] on the next edge; a free to an already-clear index or to index >= NumEntries SHALL be ignored.
REQ-021 Free and alloc in the same cycle SHALL both take effect; the alloc index SHALL be computed from pre-free state.
REQ-022 If free_idx_i equals the granted alloc_idx_o in the same cycle, the alloc SHALL win and the bit SHALL end set.
REQ-023 flush_i SHALL take priority over everything: all valid bits cleared, count_o 0, free ignored, victim pointer unchanged.
REQ-024 count_o SHALL always equal the popcount of valid_o, updated incrementally: +1 for a non-evicting grant, -1 for an effective free.
REQ-025 count_o SHALL saturate at NumEntries and never wrap.

Reset
REQ-026 On rst_ni low at a clock edge: valid_o = 0, count_o = 0, empty_o = 1, full_o = 0, victim pointer = 0.
REQ-027 Reset SHALL override every input in the same cycle, including mid-operation.
REQ-028 alloc_gnt_o SHALL be 0 while rst_ni is low.

Configuration
REQ-029 Macro IOMMU_ALLOC_VICTIM_EN: when defined, a full allocator SHALL still grant.
- alloc_idx_o = round-robin victim pointer; alloc_evict_o = 1.
- Pointer advances by 1 per evicting grant, wrapping from NumEntries-1 to 0.
REQ-030 When IOMMU_ALLOC_VICTIM_EN is undefined: no grant when full, alloc_evict_o tied 0, no victim pointer register.

Structure
REQ-031 The trailing-zero search SHALL be an instance of the existing lzc sub-module with MODE = 0 and WIDTH = NumEntries; its empty_o output SHALL mean full.
REQ-032 The entry index typedef and the NumEntries default SHALL live in the shared IOMMU package; cf_math_pkg SHALL supply idx_width.

Verification
REQ-033 Reset, then alloc_req_i=1 for 3 cycles -> indices 0,1,2; valid_o=0x0007; count_o=3.
REQ-034 valid_o=0x0007, free idx 1 -> next alloc returns idx 1; freeing clear idx 5 -> no state change.
REQ-035 Same-cycle alloc (grants idx 3) with free idx 0 from valid_o=0x0007 -> valid_o=0x000E, count_o unchanged at 3.
REQ-036 Full, NumEntries=16, macro on -> grants idx 0,1 with alloc_evict_o=1; at pointer 15 the next grant gives 15 and the pointer wraps to 0. Macro off -> alloc_gnt_o=0.
REQ-037 flush_i together with alloc_req_i and free_valid_i, from valid_o=0xFFFF -> no grant; next cycle valid_o=0, empty_o=1.
REQ-038 rst_ni low for one cycle during continuous allocation at count_o=9 -> next cycle count_o=0 and valid_o=0.

Source files
------------

// File: rtl/cf_math_pkg.sv
// ---------------------------------------------------------------------------
// cf_math_pkg
// Shared math helpers for sizing index fields.
//   idx_width(n) : bits needed to address n items, never less than 1.
// No ports (package).
// ---------------------------------------------------------------------------
package cf_math_pkg;

    // A single item still needs one bit so that index ports never collapse
    // to zero width.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/iommu_entry_alloc_pkg.sv
// ---------------------------------------------------------------------------
// iommu_entry_alloc_pkg
// Shared IOMMU definitions used by the entry allocator and its users.
//   DefaultNumEntries : default number of tracked cache entries
//   entry_idx_t       : entry index type for the default entry count
// No ports (package).
// ---------------------------------------------------------------------------
package iommu_entry_alloc_pkg;

    localparam int unsigned DefaultNumEntries = 16;

    typedef logic [cf_math_pkg::idx_width(DefaultNumEntries)-1:0] entry_idx_t;

endpackage

// File: rtl/lzc.sv
// ---------------------------------------------------------------------------
// lzc
// Leading/trailing zero counter.
//   MODE = 0 : cnt_o is the index of the lowest set bit (trailing zeros)
//   MODE = 1 : cnt_o is the number of zeros above the highest set bit
// Ports:
//   in_i    [WIDTH]     : vector to search
//   cnt_o   [CNT_WIDTH] : zero count, 0 when in_i is all zero
//   empty_o             : in_i has no set bit
// ---------------------------------------------------------------------------
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Later loop iterations overwrite earlier ones, so the scan order picks
    // the bit closest to the end being counted from.
    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        if (MODE == 1'b0) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) begin
                    cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
                end
            end
        end
    end

endmodule

// File: rtl/iommu_entry_alloc.sv
// ---------------------------------------------------------------------------
// iommu_entry_alloc
// Tracks which IOMMU cache entries hold valid data and hands out a free
// entry index per request. Optional macro IOMMU_ALLOC_VICTIM_EN lets a full
// allocator keep granting by evicting entries in round-robin order.
// Ports:
//   clk_i, rst_ni          : clock (rising edge), synchronous active-low reset
//   alloc_req_i            : request one entry this cycle
//   alloc_gnt_o            : request granted this cycle (combinational)
//   alloc_idx_o            : granted entry index
//   alloc_evict_o          : granted entry was already valid (victim)
//   free_valid_i/free_idx_i: release one entry
//   flush_i                : invalidate every entry
//   valid_o                : registered valid bitmap
//   count_o                : registered number of valid entries
//   full_o / empty_o       : all / no entries valid
// ---------------------------------------------------------------------------
module iommu_entry_alloc
    import iommu_entry_alloc_pkg::*;
#(
    parameter int unsigned NumEntries = DefaultNumEntries,
    parameter int unsigned IdxWidth   = cf_math_pkg::idx_width(NumEntries),
    parameter int unsigned CntWidth   = $clog2(NumEntries + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_req_i,
    output logic                  alloc_gnt_o,
    output logic [IdxWidth-1:0]   alloc_idx_o,
    output logic                  alloc_evict_o,
    input  logic                  free_valid_i,
    input  logic [IdxWidth-1:0]   free_idx_i,
    input  logic                  flush_i,
    output logic [NumEntries-1:0] valid_o,
    output logic [CntWidth-1:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [NumEntries-1:0] valid_q, valid_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [IdxWidth-1:0]   free_cand;
    logic                  all_valid;
    logic                  free_hit;
    logic                  grow;

    // The lowest clear valid bit is the lowest set bit of the inverted map;
    // no set bit there means every entry is in use.
    lzc #(
        .WIDTH (NumEntries),
        .MODE  (1'b0)
    ) i_free_lzc (
        .in_i    (~valid_q),
        .cnt_o   (free_cand),
        .empty_o (all_valid)
    );

`ifdef IOMMU_ALLOC_VICTIM_EN
    logic [IdxWidth-1:0] victim_ptr_q;

    // Victim pointer only moves on an evicting grant; flush blocks grants,
    // so it leaves the pointer where it was.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            victim_ptr_q <= '0;
        end else if (alloc_gnt_o && alloc_evict_o) begin
            victim_ptr_q <= (victim_ptr_q == IdxWidth'(NumEntries - 1)) ? '0
                                                                         : victim_ptr_q + 1'b1;
        end
    end
`endif

    // Grant decision. With victims enabled a full map still grants and
    // reuses the entry under the round-robin pointer.
    always_comb begin
        alloc_gnt_o   = 1'b0;
        alloc_idx_o   = free_cand;
        alloc_evict_o = 1'b0;
        if (rst_ni && alloc_req_i && !flush_i) begin
`ifdef IOMMU_ALLOC_VICTIM_EN
            alloc_gnt_o = 1'b1;
            if (all_valid) begin
                alloc_idx_o   = victim_ptr_q;
                alloc_evict_o = 1'b1;
            end
`else
            alloc_gnt_o = !all_valid;
`endif
        end
    end

    // A free only counts if it clears a bit that is set and is not the
    // entry being granted in the same cycle (the grant wins that tie).
    // Occupancy moves by +1 on a non-evicting grant and -1 on a real free,
    // so a same-cycle pair leaves it unchanged.
    always_comb begin
        free_hit = free_valid_i
                && (32'(free_idx_i) < NumEntries)
                && valid_q[free_idx_i]
                && !(alloc_gnt_o && (free_idx_i == alloc_idx_o));
        grow     = alloc_gnt_o && !alloc_evict_o;
        valid_d  = valid_q;
        count_d  = count_q;
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (free_hit) begin
                valid_d[free_idx_i] = 1'b0;
            end
            if (alloc_gnt_o) begin
                valid_d[alloc_idx_o] = 1'b1;
            end
            if (grow && !free_hit && (count_q != CntWidth'(NumEntries))) begin
                count_d = count_q + 1'b1;
            end else if (free_hit && !grow && (count_q != '0)) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign count_o = count_q;
    assign full_o  = all_valid;
    assign empty_o = (count_q == '0);

endmodule
